// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: counts in-flight writes per architectural register
// from issue to writeback and holds issue on RAW hazards or counter saturation.
module dest_reg_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_wr_en,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic              issue_use_rt,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    output logic              stall,
    output logic [NREG-1:0]   busy_vec,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic raw_rs;
    logic raw_rt;
    logic sat_dst;
    logic inc;
    logic dec;
    logic wb_under;

    // Handshake: an instruction transfers on a cycle where issue_valid && issue_ready;
    // issue_ready is combinational from current counts and flush, independent of issue_valid.
    always_comb begin
        raw_rs      = (issue_rs != '0) && (cnt[issue_rs] != '0);
        raw_rt      = issue_use_rt && (issue_rt != '0) && (cnt[issue_rt] != '0);
        sat_dst     = issue_wr_en && (issue_dst != '0) && (cnt[issue_dst] == CNT_MAX);
        issue_ready = !(raw_rs || raw_rt || sat_dst) && !flush;
        stall       = issue_valid && !issue_ready;
        inc         = issue_valid && issue_ready && issue_wr_en && (issue_dst != '0);
        dec         = wb_valid && (wb_dst != '0) && (cnt[wb_dst] != '0);
        wb_under    = wb_valid && (wb_dst != '0) && (cnt[wb_dst] == '0);
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    // Entry 0 is only ever written by reset, so it stays a constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            err_underflow <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            err_underflow <= wb_under;
            for (int i = 1; i < NREG; i++) begin
                // A same-register issue and retire cancel out.
                if (inc && (issue_dst == ADDR_W'(i)) && !(dec && (wb_dst == ADDR_W'(i)))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec && (wb_dst == ADDR_W'(i)) && !(inc && (issue_dst == ADDR_W'(i)))) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule
